// File: rtl/controlador_interrupcao.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_interrupcao
//  Brief    : Two-source interrupt controller (halt over timer). Latches
//             requests as pending flags, redirects the PC to a fixed handler
//             entry for one cycle, saves the return address for timer
//             interrupts and holds off nesting until the CPU acknowledges.
//  Revision : 1.0 - initial release
// ============================================================================
module controlador_interrupcao #(
  parameter int                  PC_WIDTH    = 11,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                int_halt,
  input  logic                int_clk,
  input  logic                getInterruption,
  input  logic [PC_WIDTH-1:0] proximoPC,
  output logic [PC_WIDTH-1:0] novoValorPC,
  output logic [PC_WIDTH-1:0] bufferPC,
  output logic [31:0]         qualInterrupcao,
  output logic                emServico
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_VECTOR  = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [31:0] C_CAUSE_NONE  = 32'd0;
  localparam logic [31:0] C_CAUSE_CLOCK = 32'd1;
  localparam logic [31:0] C_CAUSE_HALT  = 32'd2;

  logic [1:0]          state_q, state_d;
  logic                pend_halt_q, pend_halt_d;
  logic                pend_clk_q, pend_clk_d;
  logic [31:0]         qual_q, qual_d;
  logic [PC_WIDTH-1:0] bufpc_q, bufpc_d;

  // Request view combining already-pending flags with this edge's inputs, so
  // a request sampled in IDLE is taken on the very edge it is seen.
  logic halt_req_w, clk_req_w, take_w, take_halt_w, take_clk_w;

  // Decode which interrupt (if any) is accepted on the coming edge.
  always_comb begin
    halt_req_w  = pend_halt_q | int_halt;
    clk_req_w   = pend_clk_q | int_clk;
    take_w      = (state_q == S_IDLE) && (halt_req_w || clk_req_w);
    take_halt_w = take_w && halt_req_w;
    take_clk_w  = take_w && !halt_req_w && clk_req_w;
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: VECTOR is always a single cycle; ack only matters in SERVICE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (take_w) state_d = S_VECTOR;
      S_VECTOR:  state_d = S_SERVICE;
      S_SERVICE: if (getInterruption) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: PC redirect only while in VECTOR, busy flag from state.
  always_comb begin
    novoValorPC = proximoPC;
    emServico   = 1'b0;
    case (state_q)
      S_VECTOR: begin
        novoValorPC = VECTOR_ADDR;
        emServico   = 1'b1;
      end
      S_SERVICE: emServico = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: pending flags are cleared only by the interrupt that
  // consumes them; a new request on the other line still sets its own flag.
  always_comb begin
    pend_halt_d = take_halt_w ? 1'b0 : halt_req_w;
    pend_clk_d  = take_clk_w  ? 1'b0 : clk_req_w;
    qual_d      = qual_q;
    bufpc_d     = bufpc_q;
    if (take_halt_w) begin
      qual_d = C_CAUSE_HALT;
    end else if (take_clk_w) begin
      qual_d = C_CAUSE_CLOCK;
    end else if ((state_q == S_SERVICE) && getInterruption) begin
      qual_d = C_CAUSE_NONE;
    end
    // Only the timer interrupt returns to the interrupted program.
    if ((state_q == S_VECTOR) && (qual_q == C_CAUSE_CLOCK)) begin
      bufpc_d = proximoPC;
    end
  end

  // Datapath registers; reset discards in-flight and pending interrupts.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_halt_q <= 1'b0;
      pend_clk_q  <= 1'b0;
      qual_q      <= C_CAUSE_NONE;
      bufpc_q     <= '0;
    end else begin
      pend_halt_q <= pend_halt_d;
      pend_clk_q  <= pend_clk_d;
      qual_q      <= qual_d;
      bufpc_q     <= bufpc_d;
    end
  end

  assign bufferPC        = bufpc_q;
  assign qualInterrupcao = qual_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_interrupcao.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controlador_interrupcao
//  Brief    : Directed self-checking bench for controlador_interrupcao; every
//             step queues the expected outputs and compares them after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_interrupcao;

  logic        Clock;
  logic        Reset;
  logic        int_halt;
  logic        int_clk;
  logic        getInterruption;
  logic [10:0] proximoPC;
  logic [10:0] novoValorPC;
  logic [10:0] bufferPC;
  logic [31:0] qualInterrupcao;
  logic        emServico;

  int tests;
  int fails;

  typedef struct {
    logic [10:0] novo;
    logic [10:0] bpc;
    logic [31:0] qual;
    logic        em;
    string       tag;
  } exp_t;

  exp_t sb[$];

  controlador_interrupcao #(
    .PC_WIDTH    (11),
    .VECTOR_ADDR (11'd0)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .int_halt        (int_halt),
    .int_clk         (int_clk),
    .getInterruption (getInterruption),
    .proximoPC       (proximoPC),
    .novoValorPC     (novoValorPC),
    .bufferPC        (bufferPC),
    .qualInterrupcao (qualInterrupcao),
    .emServico       (emServico)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Queue the expected output set for the next comparison.
  task automatic push_exp(input logic [10:0] novo, input logic [10:0] bpc,
                          input logic [31:0] qual, input logic em, input string tag);
    exp_t e;
    e.novo = novo;
    e.bpc  = bpc;
    e.qual = qual;
    e.em   = em;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check_outputs();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (novoValorPC === e.novo) else begin
      fails++;
      $error("FAIL %s novoValorPC observed %0d expected %0d", e.tag, novoValorPC, e.novo);
    end
    tests++;
    assert (bufferPC === e.bpc) else begin
      fails++;
      $error("FAIL %s bufferPC observed %0d expected %0d", e.tag, bufferPC, e.bpc);
    end
    tests++;
    assert (qualInterrupcao === e.qual) else begin
      fails++;
      $error("FAIL %s qualInterrupcao observed %0d expected %0d", e.tag, qualInterrupcao, e.qual);
    end
    tests++;
    assert (emServico === e.em) else begin
      fails++;
      $error("FAIL %s emServico observed %0b expected %0b", e.tag, emServico, e.em);
    end
  endtask

  // One clock step: drive inputs, queue the post-edge expectation, sample 1ns after the edge.
  task automatic step(input logic h, input logic c, input logic ack, input logic [10:0] pc,
                      input logic [10:0] e_novo, input logic [10:0] e_buf,
                      input logic [31:0] e_qual, input logic e_em, input string tag);
    int_halt        = h;
    int_clk         = c;
    getInterruption = ack;
    proximoPC       = pc;
    push_exp(e_novo, e_buf, e_qual, e_em, tag);
    @(posedge Clock);
    #1;
    check_outputs();
  endtask

  // Combinational check without a clock edge.
  task automatic now_check(input logic [10:0] pc, input logic [10:0] e_novo,
                           input logic [10:0] e_buf, input logic [31:0] e_qual,
                           input logic e_em, input string tag);
    proximoPC = pc;
    push_exp(e_novo, e_buf, e_qual, e_em, tag);
    #1;
    check_outputs();
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    Reset           = 1'b0;
    int_halt        = 1'b0;
    int_clk         = 1'b0;
    getInterruption = 1'b0;
    proximoPC       = 11'd5;

    // Reset state before any edge.
    #2;
    now_check(11'd5, 11'd5, 11'd0, 32'd0, 1'b0, "reset_state");
    @(posedge Clock);
    #1;
    now_check(11'd6, 11'd6, 11'd0, 32'd0, 1'b0, "reset_held");
    Reset = 1'b1;
    #2;

    // Timer path: pulse int_clk with PC 37.
    step(1'b0, 1'b1, 1'b0, 11'd37, 11'd0,  11'd0,  32'd1, 1'b1, "timer_vector");
    step(1'b0, 1'b0, 1'b0, 11'd37, 11'd37, 11'd37, 32'd1, 1'b1, "timer_service");
    step(1'b0, 1'b0, 1'b0, 11'd37, 11'd37, 11'd37, 32'd1, 1'b1, "timer_wait");
    step(1'b0, 1'b0, 1'b1, 11'd37, 11'd37, 11'd37, 32'd0, 1'b0, "timer_ack");
    step(1'b0, 1'b0, 1'b0, 11'd37, 11'd37, 11'd37, 32'd0, 1'b0, "timer_idle");

    // Simultaneous halt and clock: halt first, ack in VECTOR ignored, clock follows.
    step(1'b1, 1'b1, 1'b0, 11'd50, 11'd0,  11'd37, 32'd2, 1'b1, "simul_vector_halt");
    step(1'b0, 1'b0, 1'b1, 11'd50, 11'd50, 11'd37, 32'd2, 1'b1, "simul_ack_in_vector");
    step(1'b0, 1'b0, 1'b1, 11'd50, 11'd50, 11'd37, 32'd0, 1'b0, "simul_ack_halt");
    step(1'b0, 1'b0, 1'b0, 11'd50, 11'd0,  11'd37, 32'd1, 1'b1, "simul_vector_clk");
    step(1'b0, 1'b0, 1'b0, 11'd50, 11'd50, 11'd50, 32'd1, 1'b1, "simul_service_clk");
    step(1'b0, 1'b0, 1'b1, 11'd50, 11'd50, 11'd50, 32'd0, 1'b0, "simul_ack_clk");

    // Masking: timer in service is held pending and bufferPC is kept.
    step(1'b0, 1'b1, 1'b0, 11'd37, 11'd0,  11'd50, 32'd1, 1'b1, "mask_vector");
    step(1'b0, 1'b0, 1'b0, 11'd37, 11'd37, 11'd37, 32'd1, 1'b1, "mask_service");
    step(1'b0, 1'b1, 1'b0, 11'd90, 11'd90, 11'd37, 32'd1, 1'b1, "mask_req_in_service");
    step(1'b0, 1'b0, 1'b0, 11'd90, 11'd90, 11'd37, 32'd1, 1'b1, "mask_hold");
    step(1'b0, 1'b0, 1'b1, 11'd90, 11'd90, 11'd37, 32'd0, 1'b0, "mask_ack");
    step(1'b0, 1'b0, 1'b0, 11'd90, 11'd0,  11'd37, 32'd1, 1'b1, "mask_revector");
    step(1'b0, 1'b0, 1'b0, 11'd90, 11'd90, 11'd90, 32'd1, 1'b1, "mask_buffer_new");
    step(1'b0, 1'b0, 1'b1, 11'd90, 11'd90, 11'd90, 32'd0, 1'b0, "mask_ack2");

    // Spurious acknowledge in IDLE.
    step(1'b0, 1'b0, 1'b1, 11'd100, 11'd100, 11'd90, 32'd0, 1'b0, "spurious_ack1");
    step(1'b0, 1'b0, 1'b1, 11'd200, 11'd200, 11'd90, 32'd0, 1'b0, "spurious_ack2");

    // Halt alone leaves bufferPC untouched.
    step(1'b1, 1'b0, 1'b0, 11'd300, 11'd0,   11'd90, 32'd2, 1'b1, "halt_vector");
    step(1'b0, 1'b0, 1'b0, 11'd300, 11'd300, 11'd90, 32'd2, 1'b1, "halt_service");
    step(1'b0, 1'b0, 1'b1, 11'd300, 11'd300, 11'd90, 32'd0, 1'b0, "halt_ack");

    // Reset during SERVICE with a timer request pending.
    step(1'b0, 1'b1, 1'b0, 11'd37, 11'd0,  11'd90, 32'd1, 1'b1, "rst_vector");
    step(1'b0, 1'b0, 1'b0, 11'd37, 11'd37, 11'd37, 32'd1, 1'b1, "rst_service");
    step(1'b0, 1'b1, 1'b0, 11'd37, 11'd37, 11'd37, 32'd1, 1'b1, "rst_pending");
    int_clk = 1'b0;
    #2;
    Reset = 1'b0;
    now_check(11'd37, 11'd37, 11'd0, 32'd0, 1'b0, "rst_immediate");
    int_clk = 1'b1;
    @(posedge Clock);
    #1;
    now_check(11'd40, 11'd40, 11'd0, 32'd0, 1'b0, "rst_held_req");
    int_clk = 1'b0;
    #1;
    Reset = 1'b1;
    #2;
    step(1'b0, 1'b0, 1'b0, 11'd41, 11'd41, 11'd0, 32'd0, 1'b0, "post_rst_idle1");
    step(1'b0, 1'b0, 1'b0, 11'd42, 11'd42, 11'd0, 32'd0, 1'b0, "post_rst_idle2");
    step(1'b0, 1'b0, 1'b0, 11'd43, 11'd43, 11'd0, 32'd0, 1'b0, "post_rst_idle3");

    // Pass-through sweep in IDLE.
    now_check(11'd0,    11'd0,    11'd0, 32'd0, 1'b0, "pass_0");
    now_check(11'd1,    11'd1,    11'd0, 32'd0, 1'b0, "pass_1");
    now_check(11'd1023, 11'd1023, 11'd0, 32'd0, 1'b0, "pass_1023");
    now_check(11'd2047, 11'd2047, 11'd0, 32'd0, 1'b0, "pass_2047");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_interrupcao.md
CONTROLADOR_INTERRUPCAO -- requirements
Module: controlador_interrupcao

Interface
REQ-001 Parameter PC_WIDTH, default 11: width of all program-counter ports.
REQ-002 Parameter VECTOR_ADDR, default 11'd0: handler entry address forced onto the PC.
REQ-003 Port Clock, input, 1: single CPU clock; all state changes on rising edge.
REQ-004 Port Reset, input, 1: asynchronous, active-low reset.
REQ-005 Port int_halt, input, 1: halt-interrupt request from the interruption source, sampled each rising edge.
REQ-006 Port int_clk, input, 1: timer-interrupt request from the interruption source, sampled each rising edge.
REQ-007 Port getInterruption, input, 1: CPU acknowledge; handler has read qualInterrupcao.
REQ-008 Port proximoPC, input, PC_WIDTH: next PC from the jump/jump-register path.
REQ-009 Port novoValorPC, output, PC_WIDTH: PC load value.
REQ-010 Port bufferPC, output, PC_WIDTH: saved return address.
REQ-011 Port qualInterrupcao, output, 32: cause code (0 none, 1 clock, 2 halt).
REQ-012 Port emServico, output, 1: high while an interrupt is being vectored or serviced.

Function
REQ-013 States: IDLE, VECTOR, SERVICE; encoding free.
REQ-014 Pending flags pend_halt and pend_clk set on any rising edge where the matching input is 1, in every state.
REQ-015 A pending flag clears only on the edge its interrupt is taken (IDLE -> VECTOR); setting wins over clearing for a different flag.
REQ-016 IDLE -> VECTOR on an edge where (pend_halt | int_halt | pend_clk | int_clk) is 1.
REQ-017 Priority: halt over clock; on the IDLE -> VECTOR edge qualInterrupcao <= 2 if halt is requested or pending, else 1.
REQ-018 Halt and clock requested together: halt taken, clock stays pending; it is taken after the halt is acknowledged.
REQ-019 VECTOR lasts exactly one cycle; novoValorPC = VECTOR_ADDR combinationally during VECTOR; VECTOR -> SERVICE unconditionally.
REQ-020 On the VECTOR -> SERVICE edge, bufferPC <= proximoPC only when qualInterrupcao = 1; for halt bufferPC holds its value.
REQ-021 Outside VECTOR, novoValorPC = proximoPC (pure pass-through, no added latency).
REQ-022 SERVICE: new requests only set pending flags; no nesting, and bufferPC is not overwritten.
REQ-023 SERVICE -> IDLE on an edge with getInterruption = 1; qualInterrupcao <= 0 on the same edge.
REQ-024 getInterruption in IDLE or VECTOR is ignored; no state or output change.
REQ-025 Pending request at the acknowledge edge: IDLE for one cycle, then VECTOR on the next edge. Interrupt-to-interrupt spacing is therefore at least 3 cycles.
REQ-026 emServico = 1 in VECTOR and SERVICE, 0 in IDLE; it is decoded from state.
REQ-027 Latency from a request sampled in IDLE to the PC redirect is 1 cycle: edge k detects the request; cycle k..k+1 drives VECTOR_ADDR.

Reset
REQ-028 Reset low: immediately state = IDLE, pend_halt = pend_clk = 0, qualInterrupcao = 0, bufferPC = 0, emServico = 0; novoValorPC = proximoPC.
REQ-029 Reset asserted mid-VECTOR or mid-SERVICE discards the in-flight interrupt and all pending requests.
REQ-030 Requests are first sampled on the first rising edge after Reset deasserts.

Verification
REQ-031 Timer path: proximoPC = 11'd37, one-cycle int_clk pulse in IDLE -> next cycle novoValorPC = 0, qualInterrupcao = 1; then bufferPC = 37, emServico = 1.
REQ-032 Simultaneous: int_halt = int_clk = 1 for one cycle -> qualInterrupcao = 2; bufferPC unchanged. Then getInterruption pulse -> 0 for one cycle; then VECTOR again with qualInterrupcao = 1.
REQ-033 Masking: int_clk pulse in SERVICE with bufferPC = 37 and proximoPC = 90 -> no redirect and bufferPC stays 37 until ack; after ack, vectors and bufferPC = proximoPC at that time.
REQ-034 Spurious ack: getInterruption = 1 in IDLE with nothing pending -> qualInterrupcao stays 0 and novoValorPC tracks proximoPC.
REQ-035 Reset mid-service: Reset low during SERVICE with clk pending -> all outputs reset immediately; after release, no VECTOR without a new request.
REQ-036 Pass-through: in IDLE, sweep proximoPC over 0, 1, 1023, 2047 -> novoValorPC equals it in the same cycle.
